// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the master ports and the arbiter:
// the port FSM states, HTRANS encodings and the slave-select helper.
package ahb_pkg;

  localparam int unsigned SEL_W = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } ahb_state_e;

  // Upper select bits address targets behind the bridge.
  function automatic logic sel_is_bridge(input logic [SEL_W-1:0] sel);
    return |sel[3:2];
  endfunction

endpackage

// File: rtl/ahb_master_port_if.sv
// Bus-side signals between one AHB master port and the arbiter/interconnect.
interface ahb_master_port_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                       hreq;
  logic                       hgrant;
  logic [ahb_pkg::SEL_W-1:0]  sel;
  logic [ADDR_W-1:0]          haddr;
  logic                       hwrite;
  logic [1:0]                 htrans;
  logic [DATA_W-1:0]          hwdata;
  logic [DATA_W-1:0]          hrdata;
  logic                       hready;
  logic                       hresp;

  modport master (
    output hreq, sel, haddr, hwrite, htrans, hwdata,
    input  hgrant, hrdata, hready, hresp
  );

  modport slave (
    input  hreq, sel, haddr, hwrite, htrans, hwdata,
    output hgrant, hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_master_port_grant_timer.sv
// Grant wait counter: loadable, clearable, flags the last allowed REQ cycle.
module ahb_grant_timer #(
  parameter int unsigned GRANT_TO = 64,
  parameter int unsigned CNT_W    = $clog2(GRANT_TO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc_c
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc_c = (r_cnt == CNT_W'(GRANT_TO - 1));
endmodule

// File: rtl/ahb_master_port.sv
// Single-beat AHB requester: takes one core command, requests the bus,
// runs one NONSEQ address phase and one data phase, then reports back.
module ahb_master_port
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned GRANT_TO = 64
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_wdata,
  input  logic [SEL_W-1:0]     cmd_sel,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  ahb_master_port_if.master    bus
);
  localparam int unsigned CNT_W = $clog2(GRANT_TO);

  ahb_state_e        r_state, w_state_nxt;
  logic              r_cmd_ready, r_rsp_valid, r_rsp_err, r_rsp_timeout;
  logic [DATA_W-1:0] r_rsp_rdata, w_rdata_nxt;
  logic              w_err_nxt, w_to_nxt;
  logic              r_hreq;
  logic [1:0]        r_htrans;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [SEL_W-1:0]  r_sel;
  logic              w_accept;
  logic              w_tmr_clr, w_tmr_load, w_tmr_en, w_tmr_tc;

  assign w_accept = (r_state == ST_IDLE) && cmd_valid;

  ahb_grant_timer #(.GRANT_TO(GRANT_TO), .CNT_W(CNT_W)) u_grant_timer (
    .clk        (hclk),
    .rst        (hreset),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val ('0),
    .i_en       (w_tmr_en),
    .o_tc_c     (w_tmr_tc)
  );

  // Next state, response payload and timer control.
  always_comb begin
    w_state_nxt = r_state;
    w_rdata_nxt = '0;
    w_err_nxt   = 1'b0;
    w_to_nxt    = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = ST_REQ;
          w_tmr_load  = 1'b1;
        end
      end
      ST_REQ: begin
        if (bus.hgrant) begin
          w_state_nxt = ST_ADDR;
          w_tmr_clr   = 1'b1;
        end else if (w_tmr_tc) begin
          w_state_nxt = ST_RESP;
          w_err_nxt   = 1'b1;
          w_to_nxt    = 1'b1;
          w_tmr_clr   = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_ADDR: begin
        if (bus.hready) begin
          w_state_nxt = ST_DATA;
        end else if (!bus.hgrant) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_DATA: begin
        // hresp only counts on the cycle hready completes the transfer.
        if (bus.hready) begin
          w_state_nxt = ST_RESP;
          w_err_nxt   = bus.hresp;
          if (!r_write) w_rdata_nxt = bus.hrdata;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_hreq        <= 1'b0;
      r_htrans      <= HTRANS_IDLE;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= (w_state_nxt == ST_IDLE);
      r_rsp_valid   <= (w_state_nxt == ST_RESP);
      r_rsp_rdata   <= w_rdata_nxt;
      r_rsp_err     <= w_err_nxt;
      r_rsp_timeout <= w_to_nxt;
      r_hreq        <= (w_state_nxt == ST_REQ) || (w_state_nxt == ST_ADDR) ||
                       (w_state_nxt == ST_DATA);
      r_htrans      <= (w_state_nxt == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    end
  end

  // Command holding registers; write data is zeroed for reads.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
    end else if (w_accept) begin
      r_write <= cmd_write;
      r_addr  <= cmd_addr;
      r_wdata <= cmd_write ? cmd_wdata : '0;
      r_sel   <= cmd_sel;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign bus.hreq    = r_hreq;
  assign bus.sel     = r_sel;
  assign bus.haddr   = r_addr;
  assign bus.hwrite  = r_write;
  assign bus.htrans  = r_htrans;
  assign bus.hwdata  = r_wdata;
endmodule

// File: tb/tb_ahb_master_port.sv
// Scoreboard bench for ahb_master_port: a procedural bus slave/arbiter drives
// each transfer and a negedge monitor checks every rsp_valid against the queue.
module tb_ahb_master_port;
  import ahb_pkg::*;

  localparam int unsigned GRANT_TO = 8;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];

  ahb_master_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_master_port #(.ADDR_W(32), .DATA_W(32), .GRANT_TO(GRANT_TO)) dut (
    .hclk        (clk),
    .hreset      (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_sel     (cmd_sel),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on each completion pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_timeout", rsp_timeout, e.to);
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_hreq", bus.hreq, 0);
        chk("rsp_ready", cmd_ready, 0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", cmd_ready, 1);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] sl);
    wait_ready();
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_sel = sl; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("req_hreq", bus.hreq, 1);
    chk("req_sel", bus.sel, sl);
    chk("req_bridge", sel_is_bridge(bus.sel), sl[3] | sl[2]);
  endtask

  // Full transfer: grant after gdly cycles, no address waits, `waits` data waits.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] sl, input int gdly, input int waits,
                          input logic [31:0] rd, input logic resp);
    exp_t e;
    issue(wr, addr, wd, sl);
    repeat (gdly) @(negedge clk);
    chk("req_htrans", bus.htrans, HTRANS_IDLE);
    bus.hgrant = 1'b1; bus.hready = 1'b1;
    e.rdata = wr ? 32'h0 : rd; e.err = resp; e.to = 1'b0; e.cyc = cyc + 3 + waits;
    exp_q.push_back(e);
    @(negedge clk);
    chk("addr_htrans", bus.htrans, HTRANS_NONSEQ);
    chk("addr_haddr", bus.haddr, addr);
    chk("addr_hwrite", bus.hwrite, wr);
    @(negedge clk);
    chk("data_htrans", bus.htrans, HTRANS_IDLE);
    chk("data_hwdata", bus.hwdata, wr ? wd : 32'h0);
    chk("data_hreq", bus.hreq, 1);
    for (int i = 0; i < waits; i++) begin
      bus.hready = 1'b0; bus.hresp = 1'b1; bus.hrdata = ~rd;
      @(negedge clk);
      chk("wait_rsp", rsp_valid, 0);
      chk("wait_haddr", bus.haddr, addr);
    end
    bus.hready = 1'b1; bus.hresp = resp; bus.hrdata = rd;
    @(negedge clk);
    bus.hgrant = 1'b0; bus.hresp = 1'b0; bus.hrdata = 32'h0;
    @(negedge clk);
    chk("post_hreq", bus.hreq, 0);
    chk("post_ready", cmd_ready, 1);
  endtask

  initial begin : main
    exp_t e;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_sel = '0; bus.hgrant = 1'b0; bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_hreq", bus.hreq, 0);
    chk("rst_htrans", bus.htrans, HTRANS_IDLE);
    chk("rst_sel", bus.sel, 0);
    chk("rst_rsp", rsp_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    run_xfer(1'b1, 32'h1000, 32'hDEADBEEF, 4'b0001, 2, 0, 32'h0, 1'b0);
    run_xfer(1'b0, 32'h2004, 32'h0, 4'b0100, 1, 3, 32'h12345678, 1'b0);
    run_xfer(1'b0, 32'h4000, 32'h0, 4'b0010, 0, 0, 32'hA5A5A5A5, 1'b1);

    // Grant never arrives: timeout response GRANT_TO+1 cycles after acceptance.
    wait_ready();
    e.rdata = 32'h0; e.err = 1'b1; e.to = 1'b1; e.cyc = cyc + GRANT_TO + 1;
    exp_q.push_back(e);
    issue(1'b0, 32'h5000, 32'h0, 4'b0001);
    wait_ready();
    chk("to_hreq", bus.hreq, 0);

    // Grant withdrawn during an address wait state, then re-granted.
    issue(1'b1, 32'h3000, 32'hCAFEF00D, 4'b1000);
    bus.hgrant = 1'b1; bus.hready = 1'b0;
    @(negedge clk);
    chk("drop_addr_htrans", bus.htrans, HTRANS_NONSEQ);
    bus.hgrant = 1'b0;
    @(negedge clk);
    chk("drop_htrans", bus.htrans, HTRANS_IDLE);
    chk("drop_hreq", bus.hreq, 1);
    bus.hgrant = 1'b1; bus.hready = 1'b1;
    e.rdata = 32'h0; e.err = 1'b0; e.to = 1'b0; e.cyc = cyc + 3;
    exp_q.push_back(e);
    @(negedge clk);
    chk("regrant_htrans", bus.htrans, HTRANS_NONSEQ);
    @(negedge clk);
    chk("regrant_hwdata", bus.hwdata, 32'hCAFEF00D);
    @(negedge clk);
    bus.hgrant = 1'b0;
    @(negedge clk);
    chk("regrant_ready", cmd_ready, 1);

    // Reset pulse in the data phase drops the command silently.
    issue(1'b0, 32'h6000, 32'h0, 4'b0001);
    bus.hgrant = 1'b1; bus.hready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstd_htrans", bus.htrans, HTRANS_IDLE);
    bus.hready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstd_ready", cmd_ready, 1);
    chk("rstd_hreq", bus.hreq, 0);
    chk("rstd_haddr", bus.haddr, 0);
    chk("rstd_sel", bus.sel, 0);
    chk("rstd_rsp", {rsp_valid, rsp_err, rsp_timeout}, 0);
    chk("rstd_rdata", rsp_rdata, 0);
    rst = 1'b0; bus.hgrant = 1'b0; bus.hready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstd_idle_ready", cmd_ready, 1);

    run_xfer(1'b0, 32'h7008, 32'h0, 4'b1100, 0, 1, 32'h0BADF00D, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete (cyc %0d)", cyc);
    $fatal(1);
  end
endmodule
